// File: rtl/uart_debug_ack_tx_pkg.sv
// uart_debug_ack_tx_pkg: shared constants, TX state type and checksum helper
package uart_debug_ack_tx_pkg;
  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 9600;
  localparam int BAUD_CNT_DEF = CLK_FREQ / UART_BPS;
  localparam int BAUD_W = 13;
  localparam int INST_DATA_W = 32;
  localparam logic [7:0] UART_ACK_MARK = 8'hA5;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  function automatic logic [7:0] xor_sum(input logic [INST_DATA_W-1:0] d);
    return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction
endpackage

// File: rtl/uart_debug_ack_tx_byte.sv
// uart_tx_byte: 8N1 serializer, LSB first, registered glitch-free output
module uart_tx_byte
  import uart_debug_ack_tx_pkg::*;
#(
  parameter int BAUD_CNT_MAX = BAUD_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);
  tx_state_e state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic tx_n, tick;
  assign tick = baud_cnt == BAUD_W'(BAUD_CNT_MAX - 1);
  assign ready_o = state == IDLE;
  always_comb begin
    state_n = state;
    baud_n = tick ? '0 : baud_cnt + 1'b1;
    bit_n = bit_cnt;
    shift_n = shift;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (valid_i) begin
          state_n = START;
          shift_n = data_i;
          bit_n = '0;
        end
      end
      START: state_n = tick ? DATA : START;
      DATA: if (tick) begin
        shift_n = shift >> 1;
        bit_n = bit_cnt + 1'b1;
        state_n = bit_cnt == 3'd7 ? STOP : DATA;
      end
      STOP: state_n = tick ? IDLE : STOP;
    endcase
    // drive the line from the next state so the output flop carries the frame
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx_o <= 1'b1;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      tx_o <= tx_n;
    end
  end
endmodule

// File: rtl/uart_debug_ack_tx.sv
// uart_debug_ack_tx: per-word XOR checksum and end-of-session trailer sent back over UART
module uart_debug_ack_tx
  import uart_debug_ack_tx_pkg::*;
#(
  parameter int BAUD_CNT_MAX = BAUD_CNT_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] TRAILER_MARK = UART_ACK_MARK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   debug_en_i,
  input  logic                   wr_en_i,
  input  logic [INST_DATA_W-1:0] wr_data_i,
  output logic                   uart_tx,
  output logic                   tx_busy_o,
  output logic                   ovf_o,
  output logic [15:0]            word_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic en_q, trail_q, rise, fall, take_word, clash, push, pop, full, empty, drop, ready;
  logic [7:0] push_data;
  assign rise = debug_en_i & ~en_q;
  assign fall = ~debug_en_i & en_q;
  assign clash = trail_q & wr_en_i & debug_en_i;
  assign take_word = wr_en_i & debug_en_i & ~trail_q;
  assign push = fall | trail_q | take_word;
  assign push_data = fall ? TRAILER_MARK : trail_q ? word_cnt_o[7:0] : xor_sum(wr_data_i);
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = ~empty & ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign drop = push & full & ~pop;
  always_ff @(posedge clk) begin
    if (push && !drop) mem[wr_ptr[AW-1:0]] <= push_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      trail_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      word_cnt_o <= '0;
      ovf_o <= 1'b0;
      tx_busy_o <= 1'b0;
    end else begin
      en_q <= debug_en_i;
      trail_q <= fall;
      if (push && !drop) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      word_cnt_o <= (rise ? 16'd0 : word_cnt_o) + 16'(take_word);
      ovf_o <= drop | clash | (ovf_o & ~rise);
      tx_busy_o <= ~empty | ~ready;
    end
  end
  uart_tx_byte #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .valid_i(~empty),
    .data_i(mem[rd_ptr[AW-1:0]]),
    .ready_o(ready),
    .tx_o(uart_tx)
  );
endmodule

// File: tb/tb_uart_debug_ack_tx.sv
// tb_uart_debug_ack_tx: randomized scoreboard bench with UART line decoder and behavioural model
module tb_uart_debug_ack_tx;
  localparam int B = 16;
  localparam int DEPTH = 4;
  localparam byte unsigned MARK = 8'hA5;
  logic clk = 0, rst_n = 0, debug_en = 0, wr_en = 0;
  logic [31:0] wr_data = 0;
  logic uart_tx, tx_busy, ovf;
  logic [15:0] word_cnt;
  int checks = 0, errors = 0, frames = 0;
  always #5 clk = ~clk;
  uart_debug_ack_tx #(.BAUD_CNT_MAX(B), .FIFO_DEPTH(DEPTH), .TRAILER_MARK(MARK)) dut (
    .clk(clk), .rst_n(rst_n), .debug_en_i(debug_en), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .uart_tx(uart_tx), .tx_busy_o(tx_busy), .ovf_o(ovf), .word_cnt_o(word_cnt)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic byte unsigned cks(input logic [31:0] d);
    byte unsigned r = 0;
    for (int i = 0; i < 4; i++) r ^= d[8*i +: 8];
    return r;
  endfunction
  // reference model: byte queue occupancy, serializer slot timing, session rules
  byte unsigned mq[$], exp_q[$];
  int unsigned cyc, next_pop;
  logic m_en_q, m_trail, m_ovf, m_rise, m_fall, m_have;
  logic [15:0] m_cnt;
  byte unsigned m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); exp_q.delete();
      cyc = 0; next_pop = 0; m_en_q = 0; m_trail = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      cyc++;
      m_rise = debug_en && !m_en_q;
      m_fall = !debug_en && m_en_q;
      if (m_rise) begin m_cnt = 0; m_ovf = 0; end
      m_have = 1;
      if (m_fall) m_b = MARK;
      else if (m_trail) begin
        m_b = m_cnt[7:0];
        if (debug_en && wr_en) m_ovf = 1;
      end else if (debug_en && wr_en) begin
        m_b = cks(wr_data);
        m_cnt++;
      end else m_have = 0;
      if (mq.size() > 0 && cyc >= next_pop) begin
        void'(mq.pop_front());
        next_pop = cyc + 10 * B + 1;
      end
      if (m_have) begin
        if (mq.size() < DEPTH) begin mq.push_back(m_b); exp_q.push_back(m_b); end
        else m_ovf = 1;
      end
      m_trail = m_fall;
      m_en_q = debug_en;
    end
  end
  // line monitor: decode 8N1 frames at mid-bit and score against expected bytes
  logic mon_on = 0;
  int mon_t, idx;
  logic [7:0] mon_byte;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) mon_on = 0;
    else begin
      if (!mon_on) begin
        if (uart_tx === 1'b0) begin mon_on = 1; mon_t = 0; end
      end else mon_t++;
      if (mon_on && mon_t % B == B / 2) begin
        idx = mon_t / B;
        if (idx == 0) check("start_bit", uart_tx, 0);
        else if (idx <= 8) mon_byte[idx-1] = uart_tx;
        else begin
          check("stop_bit", uart_tx, 1);
          frames++;
          mon_on = 0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got %0h expected none", mon_byte);
          end else check("ack_byte", mon_byte, exp_q.pop_front());
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [31:0] d);
    wr_en = 1; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    tick(3);
    while ((exp_q.size() != 0 || tx_busy) && n < 20000) begin @(negedge clk); n++; end
    check({nm, "_drain_timeout"}, n < 20000, 1);
    check({nm, "_word_cnt"}, word_cnt, m_cnt);
    check({nm, "_ovf"}, ovf, m_ovf);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int bad, k, f0;
    tick(3);
    rst_n = 1;
    // 1: idle after reset
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || word_cnt !== 16'd0) bad++;
    end
    check("t1_idle_bad_cycles", bad, 0);
    // 2: single word, latency and frame timing
    debug_en = 1; tick(2);
    wr_en = 1; wr_data = 32'h12345678;
    k = 0;
    do begin @(negedge clk); wr_en = 0; k++; end while (uart_tx && k < 10);
    check("t2_fall_latency", k, 2);
    check("t2_word_cnt", word_cnt, 1);
    tick(143);
    check("t2_bit7_low", uart_tx, 0);
    tick(1);
    check("t2_stop_high", uart_tx, 1);
    drain("t2");
    debug_en = 0;
    drain("t2_trailer");
    // 3: three words then session end
    debug_en = 1; tick(2);
    send(32'h0); tick(639);
    send(32'hFFFFFFFF); tick(639);
    send(32'hA5A5A5A5); tick(5);
    debug_en = 0;
    drain("t3");
    check("t3_ovf", ovf, 0);
    // 4: burst of six strobes overflows the FIFO
    debug_en = 1; tick(2);
    for (int i = 0; i < 6; i++) begin wr_en = 1; wr_data = $urandom; @(negedge clk); end
    wr_en = 0;
    drain("t4");
    check("t4_ovf_set", ovf, 1);
    check("t4_cnt6", word_cnt, 6);
    debug_en = 0;
    drain("t4_trailer");
    // 5: new session clears ovf; word coincident with fall is ignored
    debug_en = 1; tick(2);
    check("t5_ovf_cleared", ovf, 0);
    send($urandom); tick(200);
    send($urandom); tick(200);
    debug_en = 0; wr_en = 1; wr_data = $urandom;
    @(negedge clk); wr_en = 0;
    drain("t5");
    check("t5_cnt", word_cnt, 2);
    // 6: async reset mid-frame
    debug_en = 1; tick(2);
    send($urandom);
    k = 0;
    while (uart_tx && k < 100) begin @(negedge clk); k++; end
    check("t6_frame_started", k < 100, 1);
    tick(70);
    #1 rst_n = 0; debug_en = 0;
    #1;
    check("t6_tx_high_in_reset", uart_tx, 1);
    check("t6_busy_in_reset", tx_busy, 0);
    check("t6_cnt_in_reset", word_cnt, 0);
    tick(3);
    rst_n = 1;
    f0 = frames;
    tick(400);
    check("t6_no_byte_after_reset", frames - f0, 0);
    debug_en = 1; tick(2);
    check("t6_ovf_after_rise", ovf, 0);
    debug_en = 0;
    drain("t6");
    // random sessions, bursts and gaps
    debug_en = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) debug_en = ~debug_en;
      wr_en = $urandom_range(0, 4) != 0; wr_data = $urandom;
      @(negedge clk);
      wr_en = 0;
      tick($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(50, 400));
    end
    drain("rand_mid");
    debug_en = 0;
    drain("rand_end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
